// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core
// load/store unit (port c) and the DMA/image engine (port d).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   c_*                 core request/response port
//   d_*, d_en           DMA request/response port; d_en masks d_req
//   mem_*               memory address/data/strobes, read data in
//   c/d_grant_cnt       saturating per-port grant counters
module data_memory_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 20,
    parameter int unsigned MEM_SIZE      = 16384,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    // core port
    input  logic                     c_req,
    input  logic [ADDRESS_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0]    c_wdata,
    input  logic                     c_we,
    input  logic                     c_be,
    output logic                     c_gnt,
    output logic                     c_rvalid,
    output logic [DATA_WIDTH-1:0]    c_rdata,
    output logic                     c_err,
    // DMA port
    input  logic                     d_req,
    input  logic [ADDRESS_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0]    d_wdata,
    input  logic                     d_we,
    input  logic                     d_be,
    input  logic                     d_en,
    output logic                     d_gnt,
    output logic                     d_rvalid,
    output logic [DATA_WIDTH-1:0]    d_rdata,
    output logic                     d_err,
    // memory side
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic                     mem_be,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    // statistics
    output logic [CNT_WIDTH-1:0]     c_grant_cnt,
    output logic [CNT_WIDTH-1:0]     d_grant_cnt
);

    localparam logic [ADDRESS_WIDTH-1:0] MEM_LIMIT = ADDRESS_WIDTH'(MEM_SIZE);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e                   state_q, state_d;
    logic                     last_d_q, last_d_d;   // 1: DMA won the last arbitration
    logic                     sel_d_q, sel_d_d;     // 1: current access belongs to DMA
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     we_q, we_d;
    logic                     be_q, be_d;
    logic                     err_q, err_d;
    logic                     mem_we_q, mem_we_d;
    logic                     mem_re_q, mem_re_d;
    logic                     c_gnt_q, c_gnt_d;
    logic                     d_gnt_q, d_gnt_d;
    logic                     c_rvalid_q, c_rvalid_d;
    logic                     d_rvalid_q, d_rvalid_d;
    logic [DATA_WIDTH-1:0]    c_rdata_q, c_rdata_d;
    logic [DATA_WIDTH-1:0]    d_rdata_q, d_rdata_d;
    logic                     c_err_q, c_err_d;
    logic                     d_err_q, d_err_d;
    logic [CNT_WIDTH-1:0]     c_cnt_q, c_cnt_d;
    logic [CNT_WIDTH-1:0]     d_cnt_q, d_cnt_d;

    logic                     c_eff, d_eff, pick_d;
    logic [ADDRESS_WIDTH-1:0] win_addr;
    logic [DATA_WIDTH-1:0]    win_wdata;
    logic                     win_we, win_be, win_err;
    logic [DATA_WIDTH-1:0]    resp_data;

    // Winner selection: a lone requester wins, a tie goes to the port that did not win last.
    always_comb begin
        c_eff     = c_req;
        d_eff     = d_req & d_en;
        pick_d    = d_eff & (~c_eff | ~last_d_q);
        win_addr  = pick_d ? d_addr  : c_addr;
        win_wdata = pick_d ? d_wdata : c_wdata;
        win_we    = pick_d ? d_we    : c_we;
        win_be    = pick_d ? d_be    : c_be;
        win_err   = (win_addr >= MEM_LIMIT) | (~win_be & (win_addr[1:0] != 2'b00));
        resp_data = (~we_q & ~err_q) ? mem_read_data : '0;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        sel_d_d    = sel_d_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        be_d       = be_q;
        err_d      = err_q;
        mem_we_d   = 1'b0;
        mem_re_d   = 1'b0;
        c_gnt_d    = 1'b0;
        d_gnt_d    = 1'b0;
        c_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;
        c_err_d    = c_err_q;
        d_err_d    = d_err_q;
        c_cnt_d    = c_cnt_q;
        d_cnt_d    = d_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (c_eff | d_eff) begin
                    state_d  = ACCESS;
                    sel_d_d  = pick_d;
                    last_d_d = pick_d;
                    addr_d   = win_addr;
                    wdata_d  = win_wdata;
                    we_d     = win_we;
                    be_d     = win_be;
                    err_d    = win_err;
                    // Erroneous accesses never reach the memory strobes.
                    mem_we_d = win_we & ~win_err;
                    mem_re_d = ~win_we & ~win_err;
                    c_gnt_d  = ~pick_d;
                    d_gnt_d  = pick_d;
                    if (pick_d) begin
                        if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        if (c_cnt_q != '1) c_cnt_d = c_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            ACCESS: begin
                state_d = IDLE;
                if (sel_d_q) begin
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = resp_data;
                    d_err_d    = err_q;
                end else begin
                    c_rvalid_d = 1'b1;
                    c_rdata_d  = resp_data;
                    c_err_d    = err_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b1;
            sel_d_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= 1'b0;
            err_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            c_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            c_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
            c_err_q    <= 1'b0;
            d_err_q    <= 1'b0;
            c_cnt_q    <= '0;
            d_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            sel_d_q    <= sel_d_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            be_q       <= be_d;
            err_q      <= err_d;
            mem_we_q   <= mem_we_d;
            mem_re_q   <= mem_re_d;
            c_gnt_q    <= c_gnt_d;
            d_gnt_q    <= d_gnt_d;
            c_rvalid_q <= c_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
            c_err_q    <= c_err_d;
            d_err_q    <= d_err_d;
            c_cnt_q    <= c_cnt_d;
            d_cnt_q    <= d_cnt_d;
        end
    end

    assign c_gnt          = c_gnt_q;
    assign d_gnt          = d_gnt_q;
    assign c_rvalid       = c_rvalid_q;
    assign d_rvalid       = d_rvalid_q;
    assign c_rdata        = c_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign c_err          = c_err_q;
    assign d_err          = d_err_q;
    assign mem_address    = addr_q;
    assign mem_write_data = wdata_q;
    assign mem_be         = be_q;
    assign mem_we         = mem_we_q;
    assign mem_re         = mem_re_q;
    assign c_grant_cnt    = c_cnt_q;
    assign d_grant_cnt    = d_cnt_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: inputs change and outputs are
// sampled on the falling clock edge.
module tb_data_memory_arbiter;

    logic        clk;
    logic        rst;
    logic        c_req, c_we, c_be, c_gnt, c_rvalid, c_err;
    logic [19:0] c_addr;
    logic [31:0] c_wdata, c_rdata;
    logic        d_req, d_we, d_be, d_en, d_gnt, d_rvalid, d_err;
    logic [19:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [19:0] mem_address;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_we, mem_re, mem_be;
    logic [15:0] c_grant_cnt, d_grant_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    data_memory_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .c_req          (c_req),
        .c_addr         (c_addr),
        .c_wdata        (c_wdata),
        .c_we           (c_we),
        .c_be           (c_be),
        .c_gnt          (c_gnt),
        .c_rvalid       (c_rvalid),
        .c_rdata        (c_rdata),
        .c_err          (c_err),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_we           (d_we),
        .d_be           (d_be),
        .d_en           (d_en),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .d_err          (d_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .mem_be         (mem_be),
        .mem_read_data  (mem_read_data),
        .c_grant_cnt    (c_grant_cnt),
        .d_grant_cnt    (d_grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    initial begin
        rst = 1'b1;
        c_req = 1'b0; c_addr = '0; c_wdata = '0; c_we = 1'b0; c_be = 1'b0;
        d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = 1'b0; d_be = 1'b0;
        d_en = 1'b1;
        mem_read_data = 32'hDEADBEEF;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_c_gnt",   32'(c_gnt), 32'd0);
        check("rst_c_rvld",  32'(c_rvalid), 32'd0);
        check("rst_mem_we",  32'(mem_we), 32'd0);
        check("rst_mem_re",  32'(mem_re), 32'd0);
        check("rst_mem_adr", 32'(mem_address), 32'd0);
        check("rst_c_cnt",   32'(c_grant_cnt), 32'd0);
        rst = 1'b0;

        // core word read at 0x10
        c_req = 1'b1; c_addr = 20'h10;
        @(negedge clk);
        check("rd_c_gnt",   32'(c_gnt), 32'd1);
        check("rd_d_gnt",   32'(d_gnt), 32'd0);
        check("rd_mem_re",  32'(mem_re), 32'd1);
        check("rd_mem_we",  32'(mem_we), 32'd0);
        check("rd_mem_adr", 32'(mem_address), 32'h10);
        @(negedge clk);
        check("rd_c_rvld",  32'(c_rvalid), 32'd1);
        check("rd_c_rdata", c_rdata, 32'hDEADBEEF);
        check("rd_c_err",   32'(c_err), 32'd0);
        check("rd_d_rvld",  32'(d_rvalid), 32'd0);
        check("rd_c_gnt0",  32'(c_gnt), 32'd0);
        c_req = 1'b0;

        // reset again so the tie-break restarts with the core
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // both ports request continuously: c, d, c, d
        c_req = 1'b1; d_req = 1'b1; d_addr = 20'h20;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("alt_c_gnt", 32'(c_gnt), 32'((k % 2) == 0));
            check("alt_d_gnt", 32'(d_gnt), 32'((k % 2) == 1));
            @(negedge clk);
            check("alt_c_rvld", 32'(c_rvalid), 32'((k % 2) == 0));
            check("alt_d_rvld", 32'(d_rvalid), 32'((k % 2) == 1));
        end
        check("alt_c_cnt", 32'(c_grant_cnt), 32'd2);
        check("alt_d_cnt", 32'(d_grant_cnt), 32'd2);
        c_req = 1'b0; d_req = 1'b0;

        // DMA write at MEM_SIZE is out of range
        d_req = 1'b1; d_we = 1'b1; d_addr = 20'd16384; d_wdata = 32'h55;
        @(negedge clk);
        check("oor_d_gnt",  32'(d_gnt), 32'd1);
        check("oor_mem_we", 32'(mem_we), 32'd0);
        check("oor_mem_re", 32'(mem_re), 32'd0);
        @(negedge clk);
        check("oor_d_rvld",  32'(d_rvalid), 32'd1);
        check("oor_d_err",   32'(d_err), 32'd1);
        check("oor_d_rdata", d_rdata, 32'd0);
        check("oor_mem_we2", 32'(mem_we), 32'd0);
        d_req = 1'b0; d_we = 1'b0;

        // misaligned word write at 0x3
        c_req = 1'b1; c_we = 1'b1; c_be = 1'b0; c_addr = 20'h3; c_wdata = 32'h12345678;
        @(negedge clk);
        check("mis_c_gnt",  32'(c_gnt), 32'd1);
        check("mis_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("mis_c_rvld", 32'(c_rvalid), 32'd1);
        check("mis_c_err",  32'(c_err), 32'd1);
        check("mis_mem_we2", 32'(mem_we), 32'd0);
        // byte write at 0x3 is legal
        c_be = 1'b1; c_wdata = 32'hAB;
        @(negedge clk);
        check("bw_c_gnt",  32'(c_gnt), 32'd1);
        check("bw_mem_we", 32'(mem_we), 32'd1);
        check("bw_mem_be", 32'(mem_be), 32'd1);
        check("bw_mem_adr", 32'(mem_address), 32'h3);
        check("bw_mem_wd", mem_write_data, 32'hAB);
        @(negedge clk);
        check("bw_c_rvld",  32'(c_rvalid), 32'd1);
        check("bw_c_err",   32'(c_err), 32'd0);
        check("bw_c_rdata", c_rdata, 32'd0);
        c_req = 1'b0; c_we = 1'b0; c_be = 1'b0;

        // d_en low masks DMA even though it would win the tie
        d_en = 1'b0; c_req = 1'b1; c_addr = 20'h10; d_req = 1'b1; d_addr = 20'h20;
        @(negedge clk);
        check("den_c_gnt", 32'(c_gnt), 32'd1);
        check("den_d_gnt", 32'(d_gnt), 32'd0);
        @(negedge clk);
        check("den_c_rvld", 32'(c_rvalid), 32'd1);
        c_req = 1'b0; d_en = 1'b1;
        @(negedge clk);
        check("den_d_gnt2", 32'(d_gnt), 32'd1);
        check("den_c_gnt2", 32'(c_gnt), 32'd0);
        @(negedge clk);
        check("den_d_rvld",  32'(d_rvalid), 32'd1);
        check("den_d_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;

        // reset during the access cycle of a write
        c_req = 1'b1; c_we = 1'b1; c_addr = 20'h40; c_wdata = 32'hCAFE;
        @(negedge clk);
        check("ra_c_gnt",  32'(c_gnt), 32'd1);
        check("ra_mem_we", 32'(mem_we), 32'd1);
        rst = 1'b1; c_req = 1'b0; c_we = 1'b0;
        @(negedge clk);
        check("ra_mem_we0", 32'(mem_we), 32'd0);
        check("ra_c_rvld",  32'(c_rvalid), 32'd0);
        check("ra_c_cnt",   32'(c_grant_cnt), 32'd0);
        check("ra_d_cnt",   32'(d_grant_cnt), 32'd0);
        rst = 1'b0; c_req = 1'b1; c_addr = 20'h10; d_req = 1'b1;
        @(negedge clk);
        check("ra_tie_c_gnt", 32'(c_gnt), 32'd1);
        check("ra_tie_d_gnt", 32'(d_gnt), 32'd0);
        check("ra_tie_mem_re", 32'(mem_re), 32'd1);
        @(negedge clk);
        check("ra_tie_c_rvld", 32'(c_rvalid), 32'd1);
        c_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Two-port round-robin arbiter sharing the single-port data memory between the core load/store unit (port c) and the DMA/image engine (port d).
- Accepts one request at a time and drives the memory's address, write_data, we, re and be lines for exactly one cycle.
- Returns registered read data or a write acknowledge, and flags out-of-range and misaligned accesses as errors instead of forwarding them.
- Sits between both requesters and data_memory; it is the only driver of the memory control lines.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDRESS_WIDTH, 20, byte address width.
- MEM_SIZE, 16384, number of valid byte addresses; any address >= MEM_SIZE is an error.
- CNT_WIDTH, 16, width of the saturating grant counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- c_req  in  1  core request; held with its fields until c_gnt.
- c_addr  in  ADDRESS_WIDTH  core byte address.
- c_wdata  in  DATA_WIDTH  core write data.
- c_we  in  1  core write (1) / read (0).
- c_be  in  1  core byte access (1) / word access (0).
- c_gnt  out  1  one-cycle pulse: core request accepted.
- c_rvalid  out  1  one-cycle pulse: core response valid.
- c_rdata  out  DATA_WIDTH  core read data, valid with c_rvalid.
- c_err  out  1  core error, valid with c_rvalid.
- d_req, d_addr, d_wdata, d_we, d_be, d_gnt, d_rvalid, d_rdata, d_err: DMA port, identical to the core port.
- d_en  in  1  when 0, d_req is ignored.
- mem_address  out  ADDRESS_WIDTH  to memory.
- mem_write_data  out  DATA_WIDTH  to memory.
- mem_we  out  1  to memory.
- mem_re  out  1  to memory.
- mem_be  out  1  to memory.
- mem_read_data  in  DATA_WIDTH  combinational read data from memory.
- c_grant_cnt  out  CNT_WIDTH  saturating count of core grants.
- d_grant_cnt  out  CNT_WIDTH  saturating count of DMA grants.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, last_winner = d (so core wins the first contention), counters 0.
- Reset asserted during ACCESS: the access is aborted at that edge. mem_we/mem_re are 0 from the next cycle, and no rvalid is produced.
- FSM has two states, IDLE and ACCESS.
- IDLE, no effective request (c_req, or d_req & d_en): stay in IDLE.
- IDLE, a request is present:
  - Pick the winner. A single requester wins outright. If both request, the port that is not last_winner wins.
  - Latch the winner's addr, wdata, we and be; update last_winner.
  - Compute err = (addr >= MEM_SIZE) | (~be & addr[1:0] != 0).
  - Register gnt for the winner; move to ACCESS.
- ACCESS lasts exactly one cycle:
  - winner's gnt = 1.
  - mem_address = latched addr; mem_be = latched be; mem_write_data = latched wdata.
  - mem_we = we & ~err; mem_re = ~we & ~err.
  - At the closing edge: rdata <= (~we & ~err) ? mem_read_data : 0; winner's rvalid <= 1; err output <= err; state -> IDLE.
- Outside ACCESS: mem_we = mem_re = 0. mem_address, mem_write_data and mem_be hold their last values.
- Timing: request sampled at cycle T, gnt and memory strobe in T+1, rvalid/rdata/err in T+2.
  - Back-to-back throughput is one access per 2 cycles.
  - The requester drops or changes req in T+2; the IDLE state at T+2 may accept a new request in that same cycle.
- rdata/err hold their value after rvalid until the next response on that port. rvalid is a pulse.
- The loser's req stays pending and is served next, so no starvation occurs.
- d_en falling while d_req is pending simply masks d_req. A grant already issued completes normally.
- Counters increment on each gnt pulse and saturate at all-ones.
- Writes return rvalid with rdata = 0.
- Byte reads return whatever the memory supplies; no lane shifting is done here.

Test Plan:
- Reset, then c_req=1, c_we=0, c_be=0, c_addr=0x10, mem_read_data=0xDEADBEEF -> c_gnt at T+1 with mem_re=1, mem_address=0x10; c_rvalid=1, c_rdata=0xDEADBEEF, c_err=0 at T+2; d_* stay 0.
- Both ports request continuously -> grants alternate c, d, c, d, one every 2 cycles; after 4 grants c_grant_cnt=2 and d_grant_cnt=2.
- d_req=1, d_we=1, d_addr=MEM_SIZE (16384) -> d_gnt pulses with mem_we=0 throughout; d_rvalid=1, d_err=1, d_rdata=0.
- c_req word write with c_addr=0x3 -> c_err=1 and mem_we never asserted. Byte write (c_be=1) to 0x3 with wdata=0xAB -> mem_we=1, mem_be=1, mem_address=0x3, c_err=0.
- d_en=0 with both requesting -> only core granted. Raise d_en -> DMA granted on the next arbitration round.
- Assert rst in the ACCESS cycle of a write -> mem_we=0 from the next cycle, no rvalid, counters=0, and the next request is arbitrated from IDLE with the core winning a tie.
